multi_sound_player: RTL and testbench

Parametrised sample-playback engine that replaces the single-sound address sequencer in the audio path. It holds a table of `NUM_SOUNDS` sound regions in one shared sample ROM. On a trigger it plays the selected region once or in a loop, at a fixed sample period of `DIV` clocks. Each sample is delivered to the Audio_Controller FIFO through the `audio_out_allowed` / `write_audio_out` handshake, and the block counts samples dropped when the FIFO stalls.

---
 rtl/multi_sound_player_pkg.sv | 23 ++
 rtl/multi_sound_player_if.sv | 23 ++
 rtl/multi_sound_player_sample_out_buffer.sv | 69 ++++++
 rtl/multi_sound_player.sv | 110 +++++++++++
 tb/tb_multi_sound_player.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_sound_player_pkg.sv
// Shared constants for the multi-sound player: default sound region table and FSM state type.
package sound_pkg;

   localparam int unsigned NUM_SOUNDS_DEF = 4;
   localparam int unsigned ROM_ADDR_W_DEF = 18;

   // Entry i sits at bits [i*18 +: 18]; sound 0 is the rightmost literal.
   localparam logic [NUM_SOUNDS_DEF-1:0][ROM_ADDR_W_DEF-1:0] START_DEF =
      {18'd83255, 18'd66983, 18'd16396, 18'd0};
   localparam logic [NUM_SOUNDS_DEF-1:0][ROM_ADDR_W_DEF-1:0] END_DEF =
      {18'd137138, 18'd83254, 18'd66982, 18'd16395};

   localparam int unsigned SND_WIN    = 0;
   localparam int unsigned SND_MOO    = 1;
   localparam int unsigned SND_DETECT = 2;
   localparam int unsigned SND_CHEER  = 3;

   typedef enum logic [0:0] {
      StIdle,
      StPlay
   } state_e;

endpackage

// File: rtl/multi_sound_player_if.sv
// Audio_Controller FIFO write port: space flag, write strobe and the two channel samples.
interface multi_sound_player_if;

   logic        audio_out_allowed;
   logic        write_audio_out;
   logic [31:0] left_channel_audio_out;
   logic [31:0] right_channel_audio_out;

   modport master (
      input  audio_out_allowed,
      output write_audio_out,
      output left_channel_audio_out,
      output right_channel_audio_out
   );

   modport slave (
      output audio_out_allowed,
      input  write_audio_out,
      input  left_channel_audio_out,
      input  right_channel_audio_out
   );

endinterface

// File: rtl/multi_sound_player_sample_out_buffer.sv
// One-entry output buffer between the sample sequencer and the audio FIFO, with drop counting
// and conversion of ROM samples to left-justified signed 32-bit audio words.
module sample_out_buffer #(
   parameter int unsigned SAMPLE_W   = 6,
   parameter bit          SIGNED_ROM = 1'b0,
   parameter bit          STEREO     = 1'b0
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                capture,
   input  logic                clr_pending,
   input  logic                clr_sample,
   input  logic                playing,
   input  logic [SAMPLE_W-1:0] rom_q,
   multi_sound_player_if.master aud,
   output logic [7:0]          drop_count
);

   logic [SAMPLE_W-1:0] sample_q;
   logic [SAMPLE_W-1:0] sample_fmt;
   logic                pending_q;
   logic [7:0]          drop_q;
   logic                wr;
   logic [31:0]         conv;
   logic [31:0]         left;

   assign wr                  = pending_q & aud.audio_out_allowed;
   assign aud.write_audio_out = wr;
   assign drop_count          = drop_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sample_q  <= '0;
         pending_q <= 1'b0;
         drop_q    <= 8'd0;
      end else begin
         if (clr_sample) begin
            sample_q <= '0;
         end else if (capture) begin
            sample_q <= rom_q;
         end

         // A capture overrides a simultaneous write: the new sample stays pending, nothing lost.
         if (clr_pending) begin
            pending_q <= 1'b0;
         end else if (capture) begin
            pending_q <= 1'b1;
            if (pending_q && !wr && drop_q != 8'hFF) begin
               drop_q <= drop_q + 8'd1;
            end
         end else if (wr) begin
            pending_q <= 1'b0;
         end
      end
   end

   always_comb begin
      sample_fmt = sample_q;
      if (!SIGNED_ROM) begin
         sample_fmt[SAMPLE_W-1] = ~sample_q[SAMPLE_W-1];
      end
      conv = 32'(sample_fmt) << (32 - SAMPLE_W);
   end

   assign left                        = playing ? conv : 32'd0;
   assign aud.left_channel_audio_out  = left;
   assign aud.right_channel_audio_out = STEREO ? left : 32'd0;

endmodule

// File: rtl/multi_sound_player.sv
// Table-driven sample sequencer: plays one region of a shared sample ROM once or looped, one
// sample every DIV clocks, handing each sample to the audio FIFO through sample_out_buffer.
module multi_sound_player
   import sound_pkg::*;
#(
   parameter int unsigned ADDR_W     = 18,
   parameter int unsigned SAMPLE_W   = 6,
   parameter int unsigned NUM_SOUNDS = NUM_SOUNDS_DEF,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned DIV        = 1200,
   parameter int unsigned ROM_LAT    = 1,
   parameter bit          SIGNED_ROM = 1'b0,
   parameter bit          STEREO     = 1'b0,
   parameter logic [NUM_SOUNDS-1:0][ADDR_W-1:0] START_TABLE = START_DEF,
   parameter logic [NUM_SOUNDS-1:0][ADDR_W-1:0] END_TABLE   = END_DEF
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                play,
   input  logic                stop,
   input  logic                loop_en,
   input  logic [SEL_W-1:0]    sound_sel,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [SAMPLE_W-1:0] rom_q,
   multi_sound_player_if.master aud,
   output logic                busy,
   output logic                done,
   output logic [7:0]          drop_count
);

   localparam int unsigned IDX_W = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1;
   localparam int unsigned CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(ROM_LAT);

   state_e           state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0] div_cnt_q;
   logic [IDX_W-1:0] cur_sel_q;
   logic             cur_loop_q;
   logic             done_q;

   logic trig;
   logic at_last;
   logic at_end;
   logic finish;
   logic capture;

   // Out-of-range selections are not triggers at all, so they cannot disturb a playing sound.
   assign trig    = play && (32'(sound_sel) < NUM_SOUNDS);
   assign at_last = (state_q == StPlay) && (div_cnt_q == CNT_LAST);
   assign at_end  = (addr_q == END_TABLE[cur_sel_q]);
   assign finish  = at_last && at_end && !cur_loop_q && !stop && !trig;
   assign capture = (state_q == StPlay) && (div_cnt_q == CNT_CAP) && !stop && !trig;

   assign rom_addr = addr_q;
   assign busy     = (state_q == StPlay);
   assign done     = done_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         div_cnt_q  <= '0;
         cur_sel_q  <= '0;
         cur_loop_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (stop) begin
            state_q <= StIdle;
         end else if (trig) begin
            state_q    <= StPlay;
            addr_q     <= START_TABLE[IDX_W'(sound_sel)];
            div_cnt_q  <= '0;
            cur_sel_q  <= IDX_W'(sound_sel);
            cur_loop_q <= loop_en;
         end else if (state_q == StPlay) begin
            div_cnt_q <= at_last ? '0 : div_cnt_q + CNT_W'(1);
            if (at_last) begin
               if (!at_end) begin
                  addr_q <= addr_q + ADDR_W'(1);
               end else if (cur_loop_q) begin
                  addr_q <= START_TABLE[cur_sel_q];
               end else begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
               end
            end
         end
      end
   end

   sample_out_buffer #(
      .SAMPLE_W   (SAMPLE_W),
      .SIGNED_ROM (SIGNED_ROM),
      .STEREO     (STEREO)
   ) u_sample_out_buffer (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .capture     (capture),
      .clr_pending (stop || trig || finish),
      .clr_sample  (stop || finish),
      .playing     (busy),
      .rom_q       (rom_q),
      .aud         (aud),
      .drop_count  (drop_count)
   );

endmodule

// File: tb/tb_multi_sound_player.sv
// Scoreboard bench for multi_sound_player: DIV=4, ROM_LAT=1, ROM q = addr[5:0] one cycle later.
module tb_multi_sound_player;
   import sound_pkg::*;

   localparam logic [2:0] SEL_WIN   = 3'(SND_WIN);
   localparam logic [2:0] SEL_MOO   = 3'(SND_MOO);
   localparam logic [2:0] SEL_DET   = 3'(SND_DETECT);
   localparam logic [2:0] SEL_CHEER = 3'(SND_CHEER);

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic        stop;
   logic        loop_en;
   logic [2:0]  sound_sel;
   logic [17:0] rom_addr;
   logic [5:0]  rom_q;
   logic        busy;
   logic        done;
   logic [7:0]  drop_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int wr0;
   logic [5:0] exp_q[$];
   logic [5:0] mon_q;

   multi_sound_player_if aud_if ();

   always #5 clk = ~clk;

   always @(posedge clk) rom_q <= rom_addr[5:0];

   multi_sound_player #(
      .ADDR_W     (18),
      .SAMPLE_W   (6),
      .NUM_SOUNDS (4),
      .SEL_W      (3),
      .DIV        (4),
      .ROM_LAT    (1),
      .SIGNED_ROM (1'b0),
      .STEREO     (1'b1),
      .END_TABLE  ({18'd83256, 18'd66982, 18'd16395, 18'd3})
   ) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .play       (play),
      .stop       (stop),
      .loop_en    (loop_en),
      .sound_sel  (sound_sel),
      .rom_addr   (rom_addr),
      .rom_q      (rom_q),
      .aud        (aud_if),
      .busy       (busy),
      .done       (done),
      .drop_count (drop_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Offset-binary 6-bit sample -> MSB flipped, left-justified in 32 bits.
   function automatic logic [31:0] fmt(input logic [5:0] q);
      return {~q[5], q[4:0], 26'd0};
   endfunction

   task automatic trigger(input logic [2:0] s, input logic l);
      play      = 1'b1;
      sound_sel = s;
      loop_en   = l;
      @(posedge clk);
      #1;
      play = 1'b0;
   endtask

   // Monitor: every FIFO write must match the oldest expected sample.
   always @(negedge clk) begin
      if (aud_if.write_audio_out === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got left 0x%08h, expected no write",
                     aud_if.left_channel_audio_out);
         end else begin
            mon_q = exp_q.pop_front();
            check("write_left", aud_if.left_channel_audio_out, fmt(mon_q));
            check("write_right", aud_if.right_channel_audio_out, fmt(mon_q));
         end
      end
   end

   initial begin
      reset = 1'b1;
      play = 1'b0;
      stop = 1'b0;
      loop_en = 1'b0;
      sound_sel = 3'd0;
      aud_if.audio_out_allowed = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rom_addr", 32'(rom_addr), 0);
      check("rst_left", aud_if.left_channel_audio_out, 0);
      check("rst_right", aud_if.right_channel_audio_out, 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_write", 32'(aud_if.write_audio_out), 0);
      check("rst_drop", 32'(drop_count), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // One-shot, region 0..3
      for (int k = 0; k < 4; k++) exp_q.push_back(6'(k));
      trigger(SEL_WIN, 1'b0);
      @(negedge clk);
      check("os_busy", 32'(busy), 1);
      check("os_addr_start", 32'(rom_addr), 0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("os_addr_next", 32'(rom_addr), 1);
      repeat (11) @(posedge clk);
      @(negedge clk);
      check("os_done_early", 32'(done), 0);
      check("os_busy_late", 32'(busy), 1);
      check("os_addr_last", 32'(rom_addr), 3);
      @(posedge clk);
      @(negedge clk);
      check("os_done", 32'(done), 1);
      check("os_busy_end", 32'(busy), 0);
      check("os_left_end", aud_if.left_channel_audio_out, 0);
      check("os_right_end", aud_if.right_channel_audio_out, 0);
      check("os_addr_hold", 32'(rom_addr), 3);
      @(posedge clk);
      @(negedge clk);
      check("os_done_pulse", 32'(done), 0);
      check("os_queue", 32'(exp_q.size()), 0);

      // Loop on region 83255..83256
      for (int k = 0; k < 5; k++) exp_q.push_back((k % 2 == 0) ? 6'd55 : 6'd56);
      trigger(SEL_CHEER, 1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("loop_addr", 32'(rom_addr), (k % 2 == 0) ? 83255 : 83256);
         check("loop_no_done", 32'(done), 0);
         repeat (4) @(posedge clk);
      end
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check("loop_stop_busy", 32'(busy), 0);
      check("loop_stop_left", aud_if.left_channel_audio_out, 0);
      check("loop_queue", 32'(exp_q.size()), 0);

      // Backpressure for 10 sample periods
      aud_if.audio_out_allowed = 1'b0;
      wr0 = n_writes;
      trigger(SEL_MOO, 1'b0);
      repeat (38) @(posedge clk);
      @(negedge clk);
      check("bp_drop", 32'(drop_count), 9);
      check("bp_write_low", 32'(aud_if.write_audio_out), 0);
      check("bp_no_writes", 32'(n_writes - wr0), 0);
      exp_q.push_back(6'd21);
      @(posedge clk);
      #1;
      aud_if.audio_out_allowed = 1'b1;
      @(negedge clk);
      check("bp_write_high", 32'(aud_if.write_audio_out), 1);
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check("bp_one_write", 32'(n_writes - wr0), 1);
      check("bp_drop_hold", 32'(drop_count), 9);
      check("bp_queue", 32'(exp_q.size()), 0);

      // Format: sound 1 walks q = 12..63
      for (int k = 0; k < 52; k++) exp_q.push_back(6'(12 + k));
      trigger(SEL_MOO, 1'b0);
      repeat (82) @(posedge clk);
      @(negedge clk);
      check("fmt_q20_left", aud_if.left_channel_audio_out, 32'h0000_0000);
      repeat (124) @(posedge clk);
      @(negedge clk);
      check("fmt_q3f_left", aud_if.left_channel_audio_out, 32'h7C00_0000);
      check("fmt_q3f_right", aud_if.right_channel_audio_out, 32'h7C00_0000);
      @(posedge clk);
      #1;
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      @(negedge clk);
      check("fmt_queue", 32'(exp_q.size()), 0);

      // Invalid select, preempt, play+stop conflict
      exp_q.push_back(6'd0);
      exp_q.push_back(6'd12);
      trigger(SEL_WIN, 1'b0);
      trigger(3'd5, 1'b0);
      @(negedge clk);
      check("pre_bad_sel_addr", 32'(rom_addr), 0);
      check("pre_bad_sel_busy", 32'(busy), 1);
      repeat (3) @(posedge clk);
      #1;
      trigger(SEL_MOO, 1'b0);
      @(negedge clk);
      check("pre_addr", 32'(rom_addr), 16396);
      repeat (3) @(posedge clk);
      #1;
      play = 1'b1;
      stop = 1'b1;
      sound_sel = SEL_DET;
      @(posedge clk);
      #1;
      play = 1'b0;
      stop = 1'b0;
      @(negedge clk);
      check("conf_busy", 32'(busy), 0);
      check("conf_addr", 32'(rom_addr), 16396);
      check("conf_left", aud_if.left_channel_audio_out, 0);
      trigger(3'd5, 1'b0);
      @(negedge clk);
      check("idle_bad_sel_busy", 32'(busy), 0);
      check("pre_queue", 32'(exp_q.size()), 0);

      // Reset during sample 2
      for (int k = 0; k < 3; k++) exp_q.push_back(6'(k));
      trigger(SEL_WIN, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst2_rom_addr", 32'(rom_addr), 0);
      check("rst2_left", aud_if.left_channel_audio_out, 0);
      check("rst2_right", aud_if.right_channel_audio_out, 0);
      check("rst2_busy", 32'(busy), 0);
      check("rst2_done", 32'(done), 0);
      check("rst2_write", 32'(aud_if.write_audio_out), 0);
      check("rst2_drop", 32'(drop_count), 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst2_no_done", 32'(done), 0);
      check("rst2_queue", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
